// File: rtl/clk_en_ctrl.sv
// CPU clock-enable generator: one cpu_ce strobe every div+1 clocks, with run/halt/single-step sequencing.
// Optional strobe counter ce_count is built only when CLK_EN_CTRL_CE_COUNT_EN is defined.
module clk_en_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step_req,
  input  logic [DIV_W-1:0] div,
  input  logic             instr_end,
  input  logic             ce_count_clr,
  output logic             cpu_ce,
  output logic             halted,
  output logic             step_ack,
  output logic [31:0]      ce_count
);

  localparam logic [1:0] S_HALT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_STEP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             step_ack_q, step_ack_d;
  logic             ce;
  logic             boundary;
  logic             reload;

  // Strobe comes from registers only so the core sees a glitch-free, input-independent enable.
  assign ce       = (state_q != S_HALT) && (cnt_q == div_q);
  assign boundary = ce && instr_end;
  assign reload   = (state_q == S_HALT) || ce;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALT: begin
        if (run) begin
          state_d = S_RUN;
        end else if (step_req) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        if (!run) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (run) begin
          state_d = S_RUN;
        end else if (boundary) begin
          state_d = S_HALT;
        end
      end
      S_STEP: begin
        if (boundary) begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // The ratio is only sampled at period boundaries, so a div change never truncates a period.
  assign cnt_d      = reload ? '0 : cnt_q + DIV_W'(1);
  assign div_d      = reload ? div : div_q;
  assign step_ack_d = (state_q == S_STEP) && boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HALT;
      cnt_q      <= '0;
      div_q      <= '0;
      step_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      step_ack_q <= step_ack_d;
    end
  end

  assign cpu_ce   = ce;
  assign halted   = (state_q == S_HALT);
  assign step_ack = step_ack_q;

`ifdef CLK_EN_CTRL_CE_COUNT_EN
  logic [31:0] ce_count_q, ce_count_d;

  always_comb begin
    ce_count_d = ce_count_q;
    if (ce_count_clr) begin
      ce_count_d = '0;
    end else if (ce) begin
      ce_count_d = ce_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_count_q <= '0;
    end else begin
      ce_count_q <= ce_count_d;
    end
  end

  assign ce_count = ce_count_q;
`else
  logic unused_ce_count_clr;
  assign unused_ce_count_clr = ce_count_clr;
  assign ce_count            = '0;
`endif

endmodule

// File: tb/tb_clk_en_ctrl.sv
// Directed and randomized bench for clk_en_ctrl against a countdown-style reference model.
module tb_clk_en_ctrl;
  localparam int DIV_W = 8;
`ifdef CLK_EN_CTRL_CE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             run = 1'b0;
  logic             step_req = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic             instr_end = 1'b0;
  logic             ce_count_clr = 1'b0;
  logic             cpu_ce, halted, step_ack;
  logic [31:0]      ce_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_en_ctrl #(.DIV_W(DIV_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .step_req     (step_req),
    .div          (div),
    .instr_end    (instr_end),
    .ce_count_clr (ce_count_clr),
    .cpu_ce       (cpu_ce),
    .halted       (halted),
    .step_ack     (step_ack),
    .ce_count     (ce_count)
  );

  // Reference model: mode plus "cycles left until next strobe".
  typedef enum int {M_HALT, M_RUN, M_DRAIN, M_STEP} mode_t;
  mode_t       m_mode;
  int          m_wait;
  int          m_ratio;
  bit          m_ack;
  logic [31:0] m_count;

  function automatic bit m_ce();
    return (m_mode != M_HALT) && (m_wait == 0);
  endfunction

  task automatic model_reset();
    m_mode  = M_HALT;
    m_wait  = 0;
    m_ratio = 0;
    m_ack   = 1'b0;
    m_count = '0;
  endtask

  task automatic model_advance();
    bit ce;
    bit was_halt;
    ce       = m_ce();
    was_halt = (m_mode == M_HALT);
    m_ack    = (m_mode == M_STEP) && ce && instr_end;
    if (CNT_EN) begin
      if (ce_count_clr) m_count = '0;
      else if (ce) m_count = m_count + 32'd1;
    end
    if (was_halt || ce) begin
      m_ratio = int'(div);
      m_wait  = m_ratio;
    end else begin
      m_wait = m_wait - 1;
    end
    case (m_mode)
      M_HALT:  if (run) m_mode = M_RUN; else if (step_req) m_mode = M_STEP;
      M_RUN:   if (!run) m_mode = M_DRAIN;
      M_DRAIN: if (run) m_mode = M_RUN; else if (ce && instr_end) m_mode = M_HALT;
      M_STEP:  if (ce && instr_end) m_mode = M_HALT;
      default: m_mode = M_HALT;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    model_advance();
    @(posedge clk);
    #1;
    chk("cpu_ce", {31'd0, cpu_ce}, {31'd0, m_ce()});
    chk("halted", {31'd0, halted}, {31'd0, (m_mode == M_HALT)});
    chk("step_ack", {31'd0, step_ack}, {31'd0, m_ack});
    chk("ce_count", ce_count, m_count);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd1);
    chk("rst_step_ack", {31'd0, step_ack}, 32'd0);
    chk("rst_ce_count", ce_count, 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain_to_halt();
    run       = 1'b0;
    step_req  = 1'b0;
    instr_end = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (m_mode == M_HALT) break;
      cycle();
    end
    instr_end = 1'b0;
    chk("drain_halted", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    int strobes;
    int first_pos;
    int gap;
    int last;
    int nstrobe;
    int gaps[$];
    bit ack_seen;

    #1;
    do_reset();
    @(posedge clk);
    #1;

    // Start latency and steady spacing with div=3.
    run = 1'b1;
    div = 8'd3;
    cycle();
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("start_ce", {31'd0, cpu_ce}, {31'd0, ((k % 4) == 3)});
      chk("start_halted", {31'd0, halted}, 32'd0);
    end

    // div=0, drop run, instr_end on the 3rd strobe after the drop.
    div = 8'd0;
    for (int k = 0; k < 5; k++) cycle();
    run = 1'b0;
    strobes = 0;
    for (int k = 0; k < 30; k++) begin
      if (halted) break;
      if (cpu_ce) strobes++;
      instr_end = cpu_ce && (strobes == 3);
      cycle();
    end
    instr_end = 1'b0;
    chk("drain_strobes", strobes, 32'd3);
    chk("drain_halted", {31'd0, halted}, 32'd1);
    chk("drain_ce_off", {31'd0, cpu_ce}, 32'd0);

    // Single step with div=1; a step_req during STEP must be ignored.
    div = 8'd1;
    step_req = 1'b1;
    cycle();
    step_req = 1'b0;
    strobes = 0;
    first_pos = -1;
    gap = -1;
    for (int t = 1; t < 30; t++) begin
      if (halted) break;
      if (cpu_ce) begin
        strobes++;
        if (first_pos < 0) first_pos = t;
        else if (gap < 0) gap = t - first_pos;
      end
      instr_end = cpu_ce && (strobes == 2);
      step_req  = (t == 2);
      cycle();
    end
    step_req  = 1'b0;
    instr_end = 1'b0;
    chk("step_strobes", strobes, 32'd2);
    chk("step_gap", gap, 32'd2);
    chk("step_ack_hi", {31'd0, step_ack}, 32'd1);
    chk("step_halted", {31'd0, halted}, 32'd1);
    cycle();
    chk("step_ack_lo", {31'd0, step_ack}, 32'd0);
    chk("step_no_queue", {31'd0, halted}, 32'd1);

    // run and step_req together: run wins, no acknowledge.
    run = 1'b1;
    step_req = 1'b1;
    cycle();
    step_req = 1'b0;
    ack_seen = 1'b0;
    chk("prio_run", {31'd0, halted}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      instr_end = 1'($urandom % 2);
      cycle();
      if (step_ack) ack_seen = 1'b1;
    end
    drain_to_halt();
    chk("prio_no_ack", {31'd0, ack_seen}, 32'd0);

    // div 5 -> 1 mid-period: current period stays 6, later periods 2.
    div = 8'd5;
    run = 1'b1;
    cycle();
    last = -1;
    nstrobe = 0;
    for (int t = 1; t <= 30; t++) begin
      if (nstrobe == 1 && t == last + 2) div = 8'd1;
      cycle();
      if (cpu_ce) begin
        if (last >= 0) gaps.push_back(t - last);
        last = t;
        nstrobe++;
      end
    end
    while (gaps.size() < 3) gaps.push_back(0);
    chk("div_gap_old", gaps[0], 32'd6);
    chk("div_gap_new1", gaps[1], 32'd2);
    chk("div_gap_new2", gaps[2], 32'd2);

    // Asynchronous reset mid-RUN.
    chk("pre_rst_running", {31'd0, halted}, 32'd0);
    run = 1'b0;
    div = 8'd0;
    do_reset();

    // Strobe counter: 10 strobes, then clear coincident with a strobe.
    run = 1'b1;
    div = 8'd0;
    cycle();
    for (int k = 0; k < 10; k++) cycle();
    chk("count10", ce_count, CNT_EN ? 32'd10 : 32'd0);
    chk("count_clr_ce", {31'd0, cpu_ce}, 32'd1);
    ce_count_clr = 1'b1;
    cycle();
    ce_count_clr = 1'b0;
    chk("count_clr", ce_count, 32'd0);
    drain_to_halt();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if (($urandom % 16) == 0) run = ~run;
      step_req     = (($urandom % 6) == 0);
      div          = (($urandom % 8) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 3));
      instr_end    = 1'($urandom % 2);
      ce_count_clr = (($urandom % 40) == 0);
      if (($urandom % 200) == 0) do_reset();
      cycle();
    end
    ce_count_clr = 1'b0;
    drain_to_halt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_en_ctrl.md
# clk_en_ctrl

Clock-enable controller for the microprocessor core. It replaces free-running divided clocks with a single-clock-domain enable strobe, `cpu_ce`, produced at a programmable rate. It sequences the core through run, halt and single-step modes, and stops only at instruction boundaries. It sits between the board clock and every core register that advances per CPU cycle.

## Interface
Parameters:
- `DIV_W`, 8: width of the divide-ratio input.

Ports:
- `clk`  in  1  board clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; high requests continuous execution.
- `step_req`  in  1  one-cycle pulse; requests execution of exactly one instruction.
- `div`  in  DIV_W  divide ratio; `cpu_ce` fires once every `div`+1 clk cycles.
- `instr_end`  in  1  from the core; high when the current `cpu_ce` completes an instruction.
- `cpu_ce`  out  1  enable strobe to the core.
- `halted`  out  1  high while in HALT.
- `step_ack`  out  1  one-cycle pulse when a single step has finished.
- `ce_count`  out  32  number of `cpu_ce` strobes issued (see Configuration).
- `ce_count_clr`  in  1  synchronous clear of `ce_count` (see Configuration).

## Operation
States: HALT, RUN, DRAIN, STEP.

Internal registers:
- Phase counter `cnt` (DIV_W bits).
- Latched ratio `div_q`. It loads `div` every cycle in HALT and on every cycle where `cpu_ce`=1. `div` is therefore never used mid-period.

Strobe rule:
- `cpu_ce` = (state ≠ HALT) && (`cnt` == `div_q`).
- `cpu_ce` is decoded from registers only; no input is in its path.
- In a non-HALT state, `cnt` increments each cycle and returns to 0 on each `cpu_ce` cycle.
- In HALT, `cnt` is held at 0.
- `div`=0 gives `cpu_ce` on every cycle.

Transitions, evaluated every cycle:
- HALT: `run`=1 → RUN. Otherwise `step_req`=1 → STEP. `run` has priority.
- RUN: `run`=0 → DRAIN.
- DRAIN: `run`=1 → RUN. Otherwise `cpu_ce`&&`instr_end` → HALT.
- STEP: `cpu_ce`&&`instr_end` → HALT, with `step_ack`=1 in the next cycle. `run` is ignored in STEP.

Boundary rules:
- `step_req` outside HALT is ignored; no queuing.
- `instr_end` is ignored when `cpu_ce`=0.
- When `run` falls during the final `cpu_ce` of an instruction: RUN goes to DRAIN first. The core then finishes the *next* instruction before halting. This behaviour is required and intended.
- Halting never occurs mid-instruction.

## Timing
- Reset values: state=HALT, `cnt`=0, `div_q`=0, `cpu_ce`=0, `halted`=1, `step_ack`=0, `ce_count`=0.
- Reset acts immediately and asynchronously, including mid-RUN or mid-STEP. Release resumes in HALT.
- Start latency: `run` sampled high at edge N. The state is RUN from edge N; the first `cpu_ce` occurs `div_q` cycles after edge N. `div_q` holds the `div` value present at edge N.
- Stop latency: HALT is entered on the edge that ends the last `cpu_ce` cycle with `instr_end`=1. `halted` rises in that same edge.
- `step_ack` and `halted` rise on the same edge. `step_ack` lasts exactly one cycle.
- Spacing between consecutive `cpu_ce` strobes is exactly `div_q`+1 cycles.

## Configuration
Macro: `CLK_EN_CTRL_CE_COUNT_EN`.
- Defined: `ce_count` increments on every `cpu_ce` and wraps from 0xFFFFFFFF to 0. `ce_count_clr`=1 forces 0 on the next edge; clear wins over a coincident increment.
- Undefined: the counter is not built, `ce_count` is tied to 0, and `ce_count_clr` is unused.

## Test plan
- Reset then `run`=1, `div`=3 → `cpu_ce` first high 3 cycles after the start edge, then every 4 cycles; `halted`=0.
- RUN with `div`=0, drop `run`, `instr_end` high on the 3rd subsequent `cpu_ce` → exactly 3 strobes after the drop, then `halted`=1, `cpu_ce`=0.
- HALT, pulse `step_req`, `div`=1, `instr_end` on the 2nd strobe → 2 strobes 2 cycles apart, then `step_ack`=1 for one cycle with `halted`=1. A `step_req` pulsed during STEP has no effect.
- `run` and `step_req` high together in HALT → RUN, and no `step_ack` ever issued.
- Change `div` from 5 to 1 mid-period → the current period completes with 6 cycles, and following periods are 2 cycles.
- Assert `rst_n`=0 mid-RUN → all outputs at reset values within the same cycle. With the macro defined, 10 strobes give `ce_count`=10, and `ce_count_clr` coincident with a strobe gives 0.
